// File: rtl/voice_allocator_pkg.sv
// Shared types and widths for the band audio voice allocator.
package band_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned AMP_W    = 15;
    localparam int unsigned AGE_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Request bus from instrument players and per-voice sample/status bus to the I2S block.
interface voice_allocator_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_VOICE = 3,
    parameter int unsigned DIV_W     = 22
);
    import band_audio_pkg::*;

    localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_on;
    logic [NUM_REQ*DIV_W-1:0]      req_div;
    logic [NUM_REQ*AMP_W-1:0]      req_amp;
    logic [NUM_VOICE*SAMPLE_W-1:0] voice_left;
    logic [NUM_VOICE*SAMPLE_W-1:0] voice_right;
    logic [NUM_VOICE-1:0]          voice_busy;
    logic [NUM_VOICE*OWN_W-1:0]    voice_owner;

    modport master (
        output req_valid, req_on, req_div, req_amp,
        input  req_ready, voice_left, voice_right, voice_busy, voice_owner
    );

    modport slave (
        input  req_valid, req_on, req_div, req_amp,
        output req_ready, voice_left, voice_right, voice_busy, voice_owner
    );

endinterface

// File: rtl/voice_allocator_tone_gen.sv
// One voice: square-wave divider, optional release decay (VOICE_RELEASE_EN), registered sample.
module voice_tone_gen
    import band_audio_pkg::*;
#(
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned REL_STEP = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_on,
    input  logic                cmd_off,
    input  logic [DIV_W-1:0]    cmd_div,
    input  logic [AMP_W-1:0]    cmd_amp,
    output voice_state_t        state,
    output logic                going_idle,
    output logic [SAMPLE_W-1:0] sample
);
    voice_state_t        state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic                pol_q, pol_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, mag;
`ifdef VOICE_RELEASE_EN
    localparam int unsigned REL_W = (REL_STEP > 1) ? $clog2(REL_STEP) : 1;
    logic [REL_W-1:0]    rel_q, rel_d;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        amp_d    = amp_q;
        pol_d    = pol_q;
        mag      = SAMPLE_W'(amp_q);
        sample_d = '0;
`ifdef VOICE_RELEASE_EN
        rel_d    = rel_q;
`endif
        if (state_q != IDLE && div_q != '0) begin
            if (cnt_q == div_q - 1'b1) begin
                cnt_d = '0;
                pol_d = ~pol_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef VOICE_RELEASE_EN
        if (state_q == RELEASE) begin
            if (rel_q == REL_W'(REL_STEP - 1)) begin
                rel_d = '0;
                amp_d = amp_q >> 1;
                if (amp_q[AMP_W-1:1] == '0) state_d = IDLE;
            end else begin
                rel_d = rel_q + 1'b1;
            end
        end
        if (cmd_off && state_q == PLAY) begin
            state_d = RELEASE;
            rel_d   = '0;
        end
`else
        if (cmd_off && state_q == PLAY) state_d = IDLE;
`endif
        // Note-on (fresh or retune) always restarts the phase.
        if (cmd_on) begin
            state_d = PLAY;
            div_d   = cmd_div;
            amp_d   = cmd_amp;
            cnt_d   = '0;
            pol_d   = 1'b1;
`ifdef VOICE_RELEASE_EN
            rel_d   = '0;
`endif
        end
        if (state_q != IDLE && div_q != '0) sample_d = pol_q ? mag : (~mag + 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            amp_q    <= '0;
            pol_q    <= 1'b0;
            sample_q <= '0;
`ifdef VOICE_RELEASE_EN
            rel_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            amp_q    <= amp_d;
            pol_q    <= pol_d;
            sample_q <= sample_d;
`ifdef VOICE_RELEASE_EN
            rel_q    <= rel_d;
`endif
        end
    end

    assign state      = state_q;
    assign going_idle = (state_d == IDLE);
    assign sample     = sample_q;

endmodule

// File: rtl/voice_allocator.sv
// Round-robin request arbiter, voice allocation with oldest-voice stealing, and voice array.
// Release decay is enabled by defining VOICE_RELEASE_EN.
module voice_allocator
    import band_audio_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_VOICE = 3,
    parameter int unsigned DIV_W     = 22,
    parameter int unsigned REL_STEP  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    voice_allocator_if.slave bus
);
    localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned VID_W = (NUM_VOICE > 1) ? $clog2(NUM_VOICE) : 1;

    logic [OWN_W-1:0]    rr_q, rr_d, gnt_idx;
    logic                gnt_any, cur_on, note_on, note_off;
    logic [DIV_W-1:0]    cur_div;
    logic [AMP_W-1:0]    cur_amp;
    logic                hit_any, idle_any, rel_any, play_any;
    logic [VID_W-1:0]    hit_idx, idle_idx, rel_idx, old_idx, alloc_idx;
    logic [AGE_W-1:0]    old_age;
    logic [NUM_VOICE-1:0] cmd_on, cmd_off, going_idle;
    voice_state_t        v_state  [NUM_VOICE];
    logic [SAMPLE_W-1:0] v_sample [NUM_VOICE];
    logic [OWN_W-1:0]    owner_q  [NUM_VOICE];
    logic [OWN_W-1:0]    owner_d  [NUM_VOICE];
    logic [AGE_W-1:0]    age_q    [NUM_VOICE];
    logic [AGE_W-1:0]    age_d    [NUM_VOICE];

    always_comb begin
        logic [OWN_W:0] sum;
        sum     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_q} + (OWN_W+1)'(i);
            if (sum >= (OWN_W+1)'(NUM_REQ)) sum = sum - (OWN_W+1)'(NUM_REQ);
            if (!gnt_any && bus.req_valid[sum[OWN_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[OWN_W-1:0];
            end
        end
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_idx == OWN_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign bus.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign cur_on        = bus.req_on[gnt_idx];
    assign cur_div       = bus.req_div[gnt_idx*DIV_W +: DIV_W];
    assign cur_amp       = bus.req_amp[gnt_idx*AMP_W +: AMP_W];

    // Owner hit retunes; otherwise idle, then release, then oldest playing voice.
    always_comb begin
        hit_any  = 1'b0;  hit_idx  = '0;
        idle_any = 1'b0;  idle_idx = '0;
        rel_any  = 1'b0;  rel_idx  = '0;
        play_any = 1'b0;  old_idx  = '0;
        old_age  = '0;
        for (int unsigned v = 0; v < NUM_VOICE; v++) begin
            if (!hit_any && v_state[v] != IDLE && owner_q[v] == gnt_idx) begin
                hit_any = 1'b1;
                hit_idx = VID_W'(v);
            end
            if (!idle_any && v_state[v] == IDLE) begin
                idle_any = 1'b1;
                idle_idx = VID_W'(v);
            end
            if (!rel_any && v_state[v] == RELEASE) begin
                rel_any = 1'b1;
                rel_idx = VID_W'(v);
            end
            if (v_state[v] == PLAY && (!play_any || age_q[v] > old_age)) begin
                play_any = 1'b1;
                old_idx  = VID_W'(v);
                old_age  = age_q[v];
            end
        end
        if (hit_any)       alloc_idx = hit_idx;
        else if (idle_any) alloc_idx = idle_idx;
        else if (rel_any)  alloc_idx = rel_idx;
        else               alloc_idx = old_idx;
    end

    assign note_on  = gnt_any & cur_on;
    assign note_off = gnt_any & ~cur_on & hit_any;

    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICE; v++) begin
            cmd_on[v]  = note_on && (alloc_idx == VID_W'(v));
            cmd_off[v] = note_off && (hit_idx == VID_W'(v));
            owner_d[v] = going_idle[v] ? '0 : owner_q[v];
            age_d[v]   = age_q[v];
            if (note_on) begin
                if (alloc_idx == VID_W'(v)) begin
                    owner_d[v] = gnt_idx;
                    age_d[v]   = '0;
                end else if (v_state[v] != IDLE && age_q[v] != '1) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
            for (int unsigned v = 0; v < NUM_VOICE; v++) begin
                owner_q[v] <= '0;
                age_q[v]   <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int unsigned v = 0; v < NUM_VOICE; v++) begin
                owner_q[v] <= owner_d[v];
                age_q[v]   <= age_d[v];
            end
        end
    end

    for (genvar gv = 0; gv < NUM_VOICE; gv++) begin : g_voice
        voice_tone_gen #(
            .DIV_W    (DIV_W),
            .REL_STEP (REL_STEP)
        ) u_tone (
            .clk        (clk),
            .rst        (rst),
            .cmd_on     (cmd_on[gv]),
            .cmd_off    (cmd_off[gv]),
            .cmd_div    (cur_div),
            .cmd_amp    (cur_amp),
            .state      (v_state[gv]),
            .going_idle (going_idle[gv]),
            .sample     (v_sample[gv])
        );
        assign bus.voice_left [gv*SAMPLE_W +: SAMPLE_W] = v_sample[gv];
        assign bus.voice_right[gv*SAMPLE_W +: SAMPLE_W] = v_sample[gv];
        assign bus.voice_busy [gv]                      = (v_state[gv] != IDLE);
        assign bus.voice_owner[gv*OWN_W +: OWN_W]       = owner_q[gv];
    end

endmodule
